input_buffer_b3_loader: RTL
===========================

// Module: input_buffer_b3_loader
// PURPOSE
//  Upstream write controller for the 16-bank layer-3 input buffer (16 x 14 x 32b single-port RAMs).
//  Accepts a valid/ready stream of 32-bit feature words and scatters them bank-major:
//  word k goes to bank k%16, row k/16.
//  Drives per-bank ENA/WEA/ADDR/DIN buses that connect straight to the buffer.
//  Pulses done when the programmed number of rows is filled.
// PARAMETERS
//  NUM_BANKS  16  number of RAM banks (one-hot write lanes)
//  DATA_W     32  word width
//  ADDR_W     4   per-bank address width
//  DEPTH      14  rows per bank; max legal row index DEPTH-1
// PORTS
//  clk        in   1                  system clock, rising edge
//  rst_n      in   1                  asynchronous active-low reset
//  start      in   1                  1-cycle pulse; begins a load (honoured only in IDLE)
//  cfg_rows   in   ADDR_W+1           rows to fill, sampled on accepted start; 0 or >DEPTH -> DEPTH
//  in_valid   in   1                  stream word valid
//  in_data    in   DATA_W             stream word
//  in_ready   out  1                  loader accepts word this cycle
//  busy       out  1                  high in LOAD
//  done       out  1                  1-cycle pulse after last write issued
//  bank_ena   out  NUM_BANKS          per-bank ENA, one-hot or zero
//  bank_wea   out  NUM_BANKS          per-bank WEA, identical to bank_ena
//  bank_addr  out  NUM_BANKS*ADDR_W   per-bank ADDR, all lanes carry the same row
//  bank_din   out  NUM_BANKS*DATA_W   per-bank DIN, all lanes carry the same word
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; bank_cnt=0, row_cnt=0, rows_q=DEPTH.
//   Reset values: in_ready=0, busy=0, done=0, bank_ena/bank_wea=0, bank_addr=0, bank_din=0.
//  FSM IDLE -> LOAD -> FIN -> IDLE:
//   IDLE: in_ready=0. On start: latch rows_q (clamped), clear counters, go to LOAD.
//   LOAD: in_ready=1, busy=1. Handshake = in_valid & in_ready.
//    On handshake: register ena/wea bit bank_cnt, addr=row_cnt, din=in_data (1-cycle latency).
//    bank_cnt wraps 15->0; on wrap row_cnt increments.
//    On handshake of the last word (bank_cnt=NUM_BANKS-1, row_cnt=rows_q-1): go to FIN.
//    in_ready drops the next cycle.
//   FIN: write of the last word is on the bank outputs; done=1 for exactly this cycle; go to IDLE.
//  Cycles without a handshake: bank_ena/wea=0; addr/din hold their last value.
//  start outside IDLE is ignored, including start coincident with FIN.
//  in_valid in IDLE is ignored: no ready, no write.
//  Total words per load = 16*rows_q; the counters never address a row >= DEPTH.
// CONFIGURATION
//  Macro IB3_LOADER_ABORT_EN:
//   Defined: adds input abort (1 bit).
//    abort=1 in LOAD: go to IDLE next cycle; done is not pulsed; counters cleared.
//    A word handshaken in the same cycle as abort is still written.
//    abort has priority over the last-word -> FIN transition.
//    abort in IDLE/FIN has no effect.
//   Undefined: no abort port; a load ends only via FIN or reset.
// TESTING
//  1. Reset: rst_n=0 mid-LOAD with in_valid=1 -> all outputs 0 immediately; state IDLE after release.
//  2. Full load: start, cfg_rows=0, 224 words 0..223 back-to-back.
//     -> word 37 writes bank 5 row 2; done pulses once, 1 cycle after the word-223 write cycle.
//  3. Short load: cfg_rows=2, gapped in_valid (1 on / 2 off).
//     -> 32 writes; no ena on gap cycles; done after word 31; in_ready=0 afterwards.
//  4. start pulsed mid-LOAD and again on the FIN cycle -> ignored; counters unchanged.
//     start in the cycle after FIN -> new load at bank 0 row 0.
//  5. cfg_rows=15 -> clamped to 14; no address 14 or 15 is ever driven; done after 224 words.
//  6. (IB3_LOADER_ABORT_EN) abort with handshake on word 20 -> word 20 written to bank 4 row 1.
//     -> IDLE next cycle, no done; next start fills from bank 0 row 0.

Source files
------------

// File: rtl/input_buffer_b3_loader.sv
// Bank-major scatter loader for the 16-bank layer-3 input buffer.
// Optional abort input when IB3_LOADER_ABORT_EN is defined.
module input_buffer_b3_loader #(
  parameter int NUM_BANKS = 16,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int DEPTH     = 14
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ADDR_W:0]             cfg_rows,
`ifdef IB3_LOADER_ABORT_EN
  input  logic                        abort,
`endif
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        in_ready,
  output logic                        busy,
  output logic                        done,
  output logic [NUM_BANKS-1:0]        bank_ena,
  output logic [NUM_BANKS-1:0]        bank_wea,
  output logic [NUM_BANKS*ADDR_W-1:0] bank_addr,
  output logic [NUM_BANKS*DATA_W-1:0] bank_din
);

  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [BW-1:0] BANK_MAX = BW'(NUM_BANKS - 1);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t               state;
  logic [BW-1:0]        bank_cnt;
  logic [ADDR_W-1:0]    row_cnt;
  logic [ADDR_W:0]      rows_q;
  logic [NUM_BANKS-1:0] ena_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    din_q;

  logic            hs;
  logic            last;
  logic            abort_w;
  logic [ADDR_W:0] rows_clamp;

  assign hs = in_valid & in_ready;
  assign last = (bank_cnt == BANK_MAX) &&
                (({1'b0, row_cnt} + ONE_W) == rows_q);

  // zero or out-of-range row counts fall back to a full buffer
  assign rows_clamp = (cfg_rows == '0 || cfg_rows > DEPTH_W) ?
                      DEPTH_W : cfg_rows;

`ifdef IB3_LOADER_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bank_cnt <= '0;
      row_cnt  <= '0;
      rows_q   <= DEPTH_W;
      ena_q    <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      ena_q <= '0;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            rows_q   <= rows_clamp;
            bank_cnt <= '0;
            row_cnt  <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (hs) begin
            ena_q  <= NUM_BANKS'(1) << bank_cnt;
            addr_q <= row_cnt;
            din_q  <= in_data;
            if (bank_cnt == BANK_MAX) begin
              bank_cnt <= '0;
              row_cnt  <= row_cnt + ADDR_W'(1);
            end else begin
              bank_cnt <= bank_cnt + BW'(1);
            end
          end
          // a same-cycle word is still written, but abort wins over FIN
          if (abort_w) begin
            bank_cnt <= '0;
            row_cnt  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (hs && last) begin
            bank_cnt <= '0;
            row_cnt  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bank_ena  = ena_q;
  assign bank_wea  = ena_q;
  assign bank_addr = {NUM_BANKS{addr_q}};
  assign bank_din  = {NUM_BANKS{din_q}};

endmodule
